// File: rtl/sdf_ntt_stage.sv
// One radix-2 Cooley-Tukey forward-NTT butterfly layer as a single-path delay-feedback stage.
// Natural-order streaming, Montgomery twiddle multiply, canonical [0,Q) output, fixed latency D+MUL_LAT.
module sdf_ntt_stage #(
  parameter int unsigned W       = 16,
  parameter int unsigned Q       = 3329,
  parameter int          QINV    = -3327,
  parameter int unsigned N       = 256,
  parameter int unsigned D       = 128,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_en,
  input  logic [W-1:0]             in_data,
  output logic [$clog2(N/2)-1:0]   tw_addr,
  input  logic [W-1:0]             tw_data,
  output logic                     out_en,
  output logic [W-1:0]             out_data,
  output logic                     busy,
  output logic                     err
);

  localparam int unsigned LN  = $clog2(N);
  localparam int unsigned LD  = $clog2(D);
  localparam int unsigned TWW = $clog2(N/2);
  localparam int unsigned L   = D + MUL_LAT;
  localparam int unsigned DW  = $clog2(L + 1);

  localparam logic [W-1:0]          QW      = W'(Q);
  localparam logic [W:0]            QW1     = (W+1)'(Q);
  localparam logic [W-1:0]          QINV_W  = W'(QINV);
  localparam logic signed [2*W-1:0] Q2      = (2*W)'(Q);
  localparam logic [TWW-1:0]        TW_BASE = TWW'(N / (2*D));

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state;
  logic [LN-1:0]   cnt;
  logic [DW-1:0]   dcnt;

  logic            half, blk_start, take;
  logic [W-1:0]    x;

  logic signed [2*W-1:0] mp, mtq, md;
  logic [W-1:0]          mt, mr, mzb, mval;

  logic [W-1:0]       pv [MUL_LAT];
  logic [MUL_LAT-1:0] ph;
  logic [W-1:0]       fifo [D];
  logic [L-1:0]       vdl;

  logic [W-1:0] bv, head, lower, upper, push, res;
  logic         bh;
  logic [W:0]   sum;

  assign half      = cnt[LD];
  assign blk_start = (cnt[LD:0] == '0);
  assign busy      = (state != IDLE);
  assign tw_addr   = TW_BASE + TWW'(cnt >> (LD + 1));

  // A mid-block gap in RUN still consumes a (zero) sample so block alignment is kept.
  assign take = ((state == IDLE) && in_en) || ((state == RUN) && (in_en || !blk_start));
  assign x    = (in_en && (state != DRAIN)) ? in_data : '0;

  always_comb begin
    mp   = (2*W)'($signed(x)) * (2*W)'($signed(tw_data));
    mt   = W'(mp[W-1:0] * QINV_W);
    mtq  = (2*W)'($signed(mt)) * Q2;
    md   = mp - mtq;
    mr   = W'(md >>> W);
    mzb  = mr + (mr[W-1] ? QW : '0);
    mval = half ? mzb : x;
  end

  // Butterfly: a b-sample pairs with the a-sample at the FIFO head; an a-sample
  // is parked and the previous block's upper result leaves from the head.
  always_comb begin
    bv    = pv[MUL_LAT-1];
    bh    = ph[MUL_LAT-1];
    head  = fifo[D-1];
    sum   = {1'b0, head} + {1'b0, bv};
    lower = (sum >= QW1) ? W'(sum - QW1) : W'(sum);
    upper = (head >= bv) ? (head - bv) : (head + QW - bv);
    push  = bh ? upper : bv;
    res   = bh ? lower : head;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      dcnt  <= '0;
      err   <= 1'b0;
    end else begin
      err <= ((state == RUN) && !in_en && !blk_start) ||
             ((state == DRAIN) && in_en) ||
             (take && in_en && (in_data >= QW));
      case (state)
        IDLE: begin
          if (in_en) begin
            state <= RUN;
            cnt   <= cnt + 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (!in_en && blk_start) begin
            state <= DRAIN;
            dcnt  <= '0;
          end
        end
        DRAIN: begin
          cnt <= cnt + 1'b1;
          if (dcnt == DW'(L - 1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < MUL_LAT; i++) pv[i] <= '0;
      for (int unsigned i = 0; i < D; i++) fifo[i] <= '0;
      ph       <= '0;
      vdl      <= '0;
      out_en   <= 1'b0;
      out_data <= '0;
    end else begin
      pv[0] <= mval;
      ph[0] <= half;
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        pv[i] <= pv[i-1];
        ph[i] <= ph[i-1];
      end
      fifo[0] <= push;
      for (int unsigned i = 1; i < D; i++) fifo[i] <= fifo[i-1];
      vdl      <= {vdl[L-2:0], take};
      out_en   <= vdl[L-1];
      out_data <= res;
    end
  end

endmodule
